// File: rtl/sub32_iter.sv
// ---------------------------------------------------------------------------
// sub32_iter -- multi-cycle iterative subtractor
//
// Computes a - b one CHUNK-bit slice per clock, least-significant slice
// first, rippling the borrow (held as an inverted carry) between slices.
// On the final slice it also registers the compare flags used by the ALU's
// SUB / SLT / SLTU / branch paths. Both sides use valid/ready handshakes.
//
// Parameters
//   WIDTH      operand width (a multiple of CHUNK)
//   CHUNK      bits processed per clock; an operation takes WIDTH/CHUNK edges
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand pair a/b is valid
//   in_ready   unit is idle and will accept operands
//   a          minuend
//   b          subtrahend
//   out_valid  diff and flags are valid
//   out_ready  consumer accepts the result
//   diff       a - b modulo 2^WIDTH
//   borrow     a < b, unsigned
//   lt_signed  a < b, two's complement
//   eq         a == b
// ---------------------------------------------------------------------------
module sub32_iter #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             lt_signed,
   output logic             eq
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q;
   // Captured operands are shifted right one slice per RUN edge, so the
   // slice being worked on always sits in the low CHUNK bits.
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   // Sign bits are kept separately because the shifting copies lose them.
   logic             a_msb_q;
   logic             b_msb_q;
   logic [WIDTH-1:0] diff_q;
   logic [WIDTH-1:0] diff_d;
   logic             carry_q;
   logic             carry_d;
   logic [KW-1:0]    k_q;
   logic             out_valid_q;
   logic             borrow_q;
   logic             lt_q;
   logic             eq_q;
   logic [CHUNK:0]   chunk_sum;

   // Slice datapath: a - b == a + ~b + 1, with the +1 entering as the
   // initial carry. A carry out of the top slice means no borrow.
   // NOTE: every signal here is assigned unconditionally on every pass, so
   // the block is purely combinational and no latch can be inferred.
   always_comb begin
      chunk_sum = {1'b0, a_q[CHUNK-1:0]}
                + {1'b0, ~b_q[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, carry_q};
      carry_d   = chunk_sum[CHUNK];
      // New slice enters at the top; after NCHUNK shifts slice 0 lands at
      // bit 0 and the full difference is assembled.
      diff_d    = (diff_q >> CHUNK)
                | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
   end

   // NOTE: reset is sampled on the clock edge (synchronous), and all state
   // uses non-blocking assignments so every register updates from the
   // values present before the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         a_msb_q     <= 1'b0;
         b_msb_q     <= 1'b0;
         diff_q      <= '0;
         carry_q     <= 1'b0;
         k_q         <= '0;
         out_valid_q <= 1'b0;
         borrow_q    <= 1'b0;
         lt_q        <= 1'b0;
         eq_q        <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  a_msb_q <= a[WIDTH-1];
                  b_msb_q <= b[WIDTH-1];
                  k_q     <= '0;
                  carry_q <= 1'b1;
                  state_q <= S_RUN;
               end
            end

            S_RUN: begin
               a_q     <= a_q >> CHUNK;
               b_q     <= b_q >> CHUNK;
               diff_q  <= diff_d;
               carry_q <= carry_d;
               if (k_q == K_LAST) begin
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
                  borrow_q    <= ~carry_d;
                  eq_q        <= (diff_d == '0);
                  // Differing signs decide directly; otherwise the
                  // subtraction cannot overflow and the result sign decides.
                  lt_q        <= (a_msb_q != b_msb_q) ? a_msb_q : diff_d[WIDTH-1];
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end

            S_DONE: begin
               // Result and flags hold until the consumer takes them.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign borrow    = borrow_q;
   assign lt_signed = lt_q;
   assign eq        = eq_q;

endmodule

// File: tb/tb_sub32_iter.sv
// ---------------------------------------------------------------------------
// tb_sub32_iter -- scoreboard bench for sub32_iter
//
// The driver pushes the reference result of every accepted operand pair
// into a queue; an independent monitor pops and compares whenever the DUT
// hands over a result, and also checks latency, hold stability and
// in_ready while a result is pending.
// ---------------------------------------------------------------------------
module tb_sub32_iter;

   localparam int WIDTH  = 32;
   localparam int CHUNK  = 8;
   localparam int NCHUNK = WIDTH / CHUNK;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] diff;
      logic        borrow;
      logic        lt;
      logic        eq;
      int          acc;   // clock edge on which the operands were accepted
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;

   logic        clk         = 1'b0;
   logic        rst_n       = 1'b0;
   logic        in_valid    = 1'b0;
   logic [31:0] a           = '0;
   logic [31:0] b           = '0;
   logic        fixed_ready = 1'b1;
   logic        rnd_ready   = 1'b1;
   logic        rand_mode   = 1'b0;
   logic        out_ready;

   logic        in_ready;
   logic        out_valid;
   logic [31:0] diff;
   logic        borrow;
   logic        lt_signed;
   logic        eq;

   int          cycle    = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   logic        pending  = 1'b0;
   logic [31:0] hold_diff;
   logic        hold_borrow;
   logic        hold_lt;
   logic        hold_eq;
   logic [31:0] rx;
   logic [31:0] ry;
   bit          seen;

   assign out_ready = rand_mode ? rnd_ready : fixed_ready;

   sub32_iter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .lt_signed (lt_signed),
      .eq        (eq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;
   always @(posedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);

   // Reference model: plain arithmetic on the whole words.
   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      e.a      = x;
      e.b      = y;
      e.diff   = x - y;
      e.borrow = (x < y);
      e.lt     = ($signed(x) < $signed(y));
      e.eq     = (x == y);
      e.acc    = 0;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares the DUT's results with the scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         pending = 1'b0;
      end else if (out_valid) begin
         if (!pending) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_result: got out_valid=1 with diff=0x%08h, expected no result", diff);
            end else begin
               check("latency", 32'(cycle - sb[0].acc), 32'(NCHUNK));
            end
            hold_diff   = diff;
            hold_borrow = borrow;
            hold_lt     = lt_signed;
            hold_eq     = eq;
         end else begin
            check("hold_diff",   diff,             hold_diff);
            check("hold_borrow", 32'(borrow),      32'(hold_borrow));
            check("hold_lt",     32'(lt_signed),   32'(hold_lt));
            check("hold_eq",     32'(eq),          32'(hold_eq));
         end
         check("in_ready_busy", 32'(in_ready), 32'd0);
         if (out_ready && sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("diff",      diff,           mon_e.diff);
            check("borrow",    32'(borrow),    32'(mon_e.borrow));
            check("lt_signed", 32'(lt_signed), 32'(mon_e.lt));
            check("eq",        32'(eq),        32'(mon_e.eq));
         end
         pending = !out_ready;
      end else begin
         pending = 1'b0;
      end
   end

   // Present one operand pair and hold it until accepted.
   task automatic do_op(input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      bit   got;
      got = 1'b0;
      @(posedge clk);
      #1;
      a        = x;
      b        = y;
      in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, expected 1");
      end else begin
         e     = model(x, y);
         e.acc = cycle + 1;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !out_valid) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_diff",      diff,           32'd0);
      check("rst_borrow",    32'(borrow),    32'd0);
      check("rst_lt",        32'(lt_signed), 32'd0);
      check("rst_eq",        32'(eq),        32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);

      // Directed operand pairs
      do_op(32'h0000_0005, 32'h0000_0003);
      do_op(32'h0000_0000, 32'h0000_0001);
      do_op(32'h8000_0000, 32'h0000_0001);
      do_op(32'hDEAD_BEEF, 32'hDEAD_BEEF);
      do_op(32'h7FFF_FFFF, 32'h8000_0000);
      do_op(32'hFFFF_FFFF, 32'h0000_0000);
      wait_idle();

      // Consumer stall with new operands offered throughout
      fixed_ready = 1'b0;
      do_op(32'h1111_2222, 32'h0000_3333);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_checks++;
         n_errors++;
         $display("FAIL stall_result_timeout: got out_valid=0, expected 1");
      end
      repeat (10) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         a        = $urandom;
         b        = $urandom;
      end
      // Release with in_valid still high: the retiring edge must not accept.
      @(posedge clk);
      #1;
      fixed_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("in_ready_after_retire", 32'(in_ready), 32'd1);
      do_op(32'hCAFE_0000, 32'h0000_BABE);
      wait_idle();

      // Reset in the middle of an operation
      do_op(32'h0000_0000, 32'h0000_0001);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_diff",      diff,           32'd0);
      check("abort_borrow",    32'(borrow),    32'd0);
      check("abort_lt",        32'(lt_signed), 32'd0);
      check("abort_eq",        32'(eq),        32'd0);
      check("abort_in_ready",  32'(in_ready),  32'd1);
      do_op(32'h1234_5678, 32'h0000_0078);
      wait_idle();

      // Randomised operands with a randomly stalling consumer
      rand_mode = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         rx = $urandom;
         ry = $urandom;
         case ($urandom_range(0, 7))
            0: ry = rx;
            1: ry = rx + 32'd1;
            2: rx = {rx[31], 31'h0};
            3: ry = {~rx[31], ry[30:0]};
            default: ;
         endcase
         do_op(rx, ry);
      end
      wait_idle();
      rand_mode = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
